// File: rtl/exec_mc_ctrl_pkg.sv
// Shared constants for the execute stage: op_type values, opcode/funct
// encodings and the multi-cycle result class used by the result mux.
package exec_mc_ctrl_pkg;

   // op_type field
   localparam logic [1:0] OPT_OP   = 2'b00;
   localparam logic [1:0] OPT_FUNC = 2'b01;
   localparam logic [1:0] OPT_FPU  = 2'b10;

   // OP (op_type 00) opcodes
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_IN    = 6'h3C;
   localparam logic [5:0] OP_OUT   = 6'h3D;

   // FUNC (op_type 01) funct codes
   localparam logic [5:0] FUNC_ADD  = 6'h20;
   localparam logic [5:0] FUNC_SUB  = 6'h22;
   localparam logic [5:0] FUNC_AND  = 6'h24;
   localparam logic [5:0] FUNC_MULT = 6'h18;
   localparam logic [5:0] FUNC_DIV  = 6'h1A;

   // FPU (op_type 10) function codes
   localparam logic [5:0] FPU_ADD  = 6'h00;
   localparam logic [5:0] FPU_SUB  = 6'h01;
   localparam logic [5:0] FPU_MUL  = 6'h02;
   localparam logic [5:0] FPU_INV  = 6'h04;
   localparam logic [5:0] FPU_SQRT = 6'h05;
   localparam logic [5:0] FPU_CMP  = 6'h06;
   localparam logic [5:0] FPU_MOV  = 6'h07;

   // Result class of an issued instruction; also the result-select code.
   typedef enum logic [2:0] {
      MC_SINGLE = 3'd0,
      MC_MUL    = 3'd1,
      MC_DIV    = 3'd2,
      MC_FPU    = 3'd3,
      MC_UART   = 3'd4
   } mc_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational classifier: (op_type, instr) -> multi-cycle class.
// Kept separate so the hazard unit can reuse the same decode.
module mc_decode
   import exec_mc_ctrl_pkg::*;
(
   input  logic [1:0] op_type,
   input  logic [5:0] instr,
   output mc_class_t  mc_class
);

   // Map the opcode/funct to its owning unit; anything unknown is single-cycle.
   always_comb begin
      mc_class = MC_SINGLE;
      case (op_type)
         OPT_OP: begin
            if (instr == OP_IN || instr == OP_OUT) begin
               mc_class = MC_UART;
            end
         end
         OPT_FUNC: begin
            if (instr == FUNC_MULT) begin
               mc_class = MC_MUL;
            end else if (instr == FUNC_DIV) begin
               mc_class = MC_DIV;
            end
         end
         OPT_FPU: begin
            if (instr == FPU_ADD || instr == FPU_SUB || instr == FPU_MUL ||
                instr == FPU_INV || instr == FPU_SQRT) begin
               mc_class = MC_FPU;
            end
         end
         default: mc_class = MC_SINGLE;
      endcase
   end

endmodule

// File: rtl/exec_mc_ctrl.sv
// Execute-stage multi-cycle sequencer: holds stall while the owning unit
// (multiplier, FPU, divider or UART) works, then pulses done for one cycle.
module exec_mc_ctrl
   import exec_mc_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT     = 3,
   parameter int unsigned FPU_LAT     = 4,
   parameter int unsigned DIV_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [1:0] op_type,
   input  logic [5:0] instr,
   input  logic       div_valid,
   input  logic       uart_busy,
   output logic       stall,
   output logic       div_go,
   output logic       done,
   output logic [2:0] res_sel,
   output logic       timeout_err
);

   // The counter serves both the fixed-latency countdown (6 bits) and the
   // divider timeout count-up, so it takes the wider of the two.
   localparam int unsigned DIV_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
   localparam int unsigned CNT_W = (DIV_W > 6) ? DIV_W : 6;

   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] FPU_INIT = CNT_W'(FPU_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIXED,
      S_DIV_WAIT,
      S_UART_WAIT,
      S_DONE
   } state_t;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   mc_class_t        res_sel_q, res_sel_d;
   logic             div_go_q,  div_go_d;
   logic             timeout_q, timeout_d;
   mc_class_t        dec_class;

   mc_decode u_decode (
      .op_type  (op_type),
      .instr    (instr),
      .mc_class (dec_class)
   );

   // Next-state, counter and output logic; stall is combinational so the issue cycle itself stalls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      res_sel_d = res_sel_q;
      div_go_d  = 1'b0;
      timeout_d = timeout_q;
      stall     = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               res_sel_d = dec_class;
               case (dec_class)
                  MC_MUL: begin
                     state_d = S_FIXED;
                     cnt_d   = MUL_INIT;
                     stall   = 1'b1;
                  end
                  MC_FPU: begin
                     state_d = S_FIXED;
                     cnt_d   = FPU_INIT;
                     stall   = 1'b1;
                  end
                  MC_DIV: begin
                     state_d  = S_DIV_WAIT;
                     cnt_d    = '0;
                     div_go_d = 1'b1;
                     stall    = 1'b1;
                  end
                  MC_UART: begin
                     state_d = S_UART_WAIT;
                     stall   = 1'b1;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_FIXED: begin
            stall = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DIV_WAIT: begin
            stall = 1'b1;
            // A result arriving on the timeout cycle still counts as success.
            if (div_valid) begin
               state_d = S_DONE;
            end else if (cnt_q == DIV_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_UART_WAIT: begin
            stall = 1'b1;
            if (!uart_busy) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and control registers; reset aborts any operation without a done.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         res_sel_q <= MC_SINGLE;
         div_go_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_sel_q <= res_sel_d;
         div_go_q  <= div_go_d;
         timeout_q <= timeout_d;
      end
   end

   assign div_go      = div_go_q;
   assign res_sel     = res_sel_q;
   assign timeout_err = timeout_q;

endmodule
